// File: rtl/m1_mem_req_stage_pkg.sv
// Shared definitions for the M1 memory-request stage: exception codes, FSM states,
// access sizes and the store-lane alignment helpers.
package m1_mem_req_stage_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } m1_state_e;

  // Half-word strobes look only at a[1] so an unchecked odd address still hits one aligned half.
  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] s;
    case (size)
      SIZE_BYTE: s = 4'b0001 << a;
      SIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
      default:   s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {4{d[7:0]}};
      SIZE_HALF: r = {2{d[15:0]}};
      default:   r = d;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SIZE_HALF) && a[0]) || ((size == SIZE_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/m1_mem_req_stage_if.sv
// DCache request/response bus between the M1 stage (master) and the data cache (slave).
interface m1_mem_req_stage_if #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
);
  logic                req_valid;
  logic                req_ready;
  logic                req_op;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic [3:0]          req_wstrb;
  logic [31:0]         req_wdata;
  logic                req_uncached;
  logic                resp_done;

  modport master (
    output req_valid, req_op, req_tag, req_index, req_offset,
           req_wstrb, req_wdata, req_uncached,
    input  req_ready, resp_done
  );

  modport slave (
    input  req_valid, req_op, req_tag, req_index, req_offset,
           req_wstrb, req_wdata, req_uncached,
    output req_ready, resp_done
  );
endinterface

// File: rtl/m1_mem_req_stage_addr_map.sv
// Combinational VA->PA map: kseg0/kseg1 strip the top three bits, kseg1 is uncached,
// every other segment passes through. Shared with the instruction-fetch side.
module m1_addr_map #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_va,
  output logic [ADDR_W-1:0] o_pa,
  output logic              o_uncached
);
  logic [2:0] w_seg;

  assign w_seg = i_va[ADDR_W-1 -: 3];

  always_comb begin
    o_pa       = i_va;
    o_uncached = 1'b0;
    if ((w_seg == 3'b100) || (w_seg == 3'b101)) begin
      o_pa = {3'b000, i_va[ADDR_W-4:0]};
    end
    o_uncached = (w_seg == 3'b101);
  end
endmodule

// File: rtl/m1_mem_req_stage.sv
// M1 stage between EXE and MEM: registers one memory op, issues one DCache request per op
// and tracks outstanding requests. Optional alignment check: M1_MISALIGN_CHECK_EN.
module m1_mem_req_stage
  import m1_mem_req_stage_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int INDEX_W   = 8,
  parameter int OFFSET_W  = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           es_valid,
  output logic                           m1_allowin,
  input  logic [ADDR_W-1:0]              es_pc,
  input  logic [ADDR_W-1:0]              es_addr,
  input  logic [31:0]                    es_wdata,
  input  logic                           es_load,
  input  logic                           es_store,
  input  logic [1:0]                     es_size,
  input  logic                           es_ex,
  input  logic                           flush,
  input  logic                           ms_allowin,
  output logic                           m1_to_ms_valid,
  output logic [ADDR_W-1:0]              m1_pc,
  output logic [ADDR_W-1:0]              m1_addr,
  output logic                           m1_ex,
  output logic [4:0]                     m1_excode,
  output logic                           m1_load_op,
  m1_mem_req_stage_if.master             dc,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  m1_state_e          r_state;
  m1_state_e          w_state_nxt;
  logic               r_valid;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_load;
  logic               r_store;
  logic               r_ex;
  logic [4:0]         r_excode;
  logic [3:0]         r_wstrb;
  logic [31:0]        r_wdata;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_load_en;
  logic               w_mem_op;
  logic               w_new_ex;
  logic [4:0]         w_new_excode;
  logic               w_cnt_room;
  logic               w_accept;
  logic               w_resp;
  logic [ADDR_W-1:0]  w_pa;
  logic               w_uncached;

  assign w_mem_op   = es_load | es_store;
  assign w_cnt_room = (r_cnt < CNT_W'(MAX_OUTST));
  assign m1_allowin = ~r_valid | ((r_state == ST_DONE) & ms_allowin);
  assign w_load_en  = es_valid & m1_allowin & ~flush;

`ifdef M1_MISALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign   = w_mem_op & is_misaligned(es_size, es_addr[1:0]);
  assign w_new_ex     = es_ex | w_misalign;
  assign w_new_excode = (w_misalign & ~es_ex) ? (es_store ? EXC_ADES : EXC_ADEL) : EXC_NONE;
`else
  assign w_new_ex     = es_ex;
  assign w_new_excode = EXC_NONE;
`endif

  // Flush only blocks new requests; ones already accepted still return resp_done.
  assign dc.req_valid = (r_state == ST_ISSUE) & ~flush & w_cnt_room;
  assign w_accept     = dc.req_valid & dc.req_ready;
  assign w_resp       = dc.resp_done & (r_cnt != '0);

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else if (w_load_en) begin
      w_state_nxt = (w_mem_op & ~w_new_ex) ? ST_ISSUE : ST_DONE;
    end else if (m1_allowin) begin
      w_state_nxt = ST_IDLE;
    end else if (w_accept) begin
      w_state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_addr   <= '0;
      r_load   <= 1'b0;
      r_store  <= 1'b0;
      r_ex     <= 1'b0;
      r_excode <= EXC_NONE;
      r_wstrb  <= 4'b0000;
      r_wdata  <= 32'h0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load_en) begin
      r_valid  <= 1'b1;
      r_pc     <= es_pc;
      r_addr   <= es_addr;
      r_load   <= es_load;
      r_store  <= es_store;
      r_ex     <= w_new_ex;
      r_excode <= w_new_excode;
      r_wstrb  <= es_store ? store_strobe(es_size, es_addr[1:0]) : 4'b0000;
      r_wdata  <= es_store ? store_data(es_size, es_wdata) : 32'h0;
    end else if (m1_allowin) begin
      r_valid <= 1'b0;
    end
  end

  // Accept and completion in the same edge cancel; the issue gate keeps the count from overflowing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (w_accept & ~w_resp) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_resp & ~w_accept) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  m1_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
    .i_va       (r_addr),
    .o_pa       (w_pa),
    .o_uncached (w_uncached)
  );

  assign dc.req_op       = r_store;
  assign dc.req_tag      = w_pa[ADDR_W-1 -: TAG_W];
  assign dc.req_index    = w_pa[OFFSET_W +: INDEX_W];
  assign dc.req_offset   = w_pa[OFFSET_W-1:0];
  assign dc.req_wstrb    = r_wstrb;
  assign dc.req_wdata    = r_wdata;
  assign dc.req_uncached = w_uncached;

  assign m1_to_ms_valid = r_valid & (r_state == ST_DONE);
  assign m1_pc          = r_pc;
  assign m1_addr        = r_addr;
  assign m1_ex          = r_ex;
  assign m1_excode      = r_excode;
  assign m1_load_op     = r_load;
  assign outst_cnt      = r_cnt;

endmodule

// File: tb/tb_m1_mem_req_stage.sv
// Self-checking bench for m1_mem_req_stage: directed cases then randomized ops checked
// against an arithmetic reference model of address mapping, strobes and request counting.
module tb_m1_mem_req_stage;
  import m1_mem_req_stage_pkg::*;

  localparam int MAX_OUTST = 2;

  logic        clk;
  logic        resetn;
  logic        es_valid;
  logic        m1_allowin;
  logic [31:0] es_pc;
  logic [31:0] es_addr;
  logic [31:0] es_wdata;
  logic        es_load;
  logic        es_store;
  logic [1:0]  es_size;
  logic        es_ex;
  logic        flush;
  logic        ms_allowin;
  logic        m1_to_ms_valid;
  logic [31:0] m1_pc;
  logic [31:0] m1_addr;
  logic        m1_ex;
  logic [4:0]  m1_excode;
  logic        m1_load_op;
  logic [1:0]  outst_cnt;

  int errors = 0;
  int checks = 0;
  int expCnt = 0;

  m1_mem_req_stage_if #(.TAG_W(20), .INDEX_W(8), .OFFSET_W(4)) dcIf ();

  m1_mem_req_stage #(
    .ADDR_W(32), .INDEX_W(8), .OFFSET_W(4), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .es_valid       (es_valid),
    .m1_allowin     (m1_allowin),
    .es_pc          (es_pc),
    .es_addr        (es_addr),
    .es_wdata       (es_wdata),
    .es_load        (es_load),
    .es_store       (es_store),
    .es_size        (es_size),
    .es_ex          (es_ex),
    .flush          (flush),
    .ms_allowin     (ms_allowin),
    .m1_to_ms_valid (m1_to_ms_valid),
    .m1_pc          (m1_pc),
    .m1_addr        (m1_addr),
    .m1_ex          (m1_ex),
    .m1_excode      (m1_excode),
    .m1_load_op     (m1_load_op),
    .dc             (dcIf.master),
    .outst_cnt      (outst_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: segment arithmetic on the address, strobes/data by lane arithmetic.
  function automatic logic [31:0] modelPa(input logic [31:0] va);
    int unsigned seg;
    seg = va / 32'h2000_0000;
    if (seg == 4 || seg == 5) return va % 32'h2000_0000;
    return va;
  endfunction

  function automatic logic modelUncached(input logic [31:0] va);
    return (va / 32'h2000_0000) == 5;
  endfunction

  function automatic logic [3:0] modelStrobe(input bit st, input int sz, input int a);
    if (!st) return 4'h0;
    if (sz == 0) return 4'(1 << a);
    if (sz == 1) return (a >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] modelWdata(input int sz, input logic [31:0] d);
    if (sz == 0) return (d % 256) * 32'h0101_0101;
    if (sz == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit modelMisaligned(input int sz, input int a);
`ifdef M1_MISALIGN_CHECK_EN
    return (sz == 1 && (a % 2) != 0) || (sz == 2 && a != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] pc, input logic [31:0] va,
                               input logic [31:0] d, input bit ld, input bit st,
                               input logic [1:0] sz, input bit ex);
    es_valid = v;
    es_pc    = pc;
    es_addr  = va;
    es_wdata = d;
    es_load  = ld;
    es_store = st;
    es_size  = sz;
    es_ex    = ex;
  endtask

  task automatic pulseResp();
    dcIf.resp_done = 1'b1;
    @(posedge clk); #1;
    dcIf.resp_done = 1'b0;
    expCnt--;
    @(negedge clk);
    checkOutput("outstAfterResp", outst_cnt, expCnt);
    @(posedge clk); #1;
  endtask

  // Runs one op from an empty stage; called and returns at posedge+1.
  task automatic runOp(input logic [31:0] pc, input logic [31:0] va, input logic [31:0] d,
                       input bit ld, input bit st, input logic [1:0] sz, input bit ex,
                       input int rdyDelay, input int msDelay, input bit respAtAccept);
    bit          mis;
    bit          issue;
    logic [4:0]  expCode;
    logic [31:0] pa;
    mis     = (ld || st) && modelMisaligned(sz, va % 4);
    issue   = (ld || st) && !ex && !mis;
    expCode = (mis && !ex) ? (st ? 5'd5 : 5'd4) : 5'd0;
    pa      = modelPa(va);
    applyStimulus(1'b1, pc, va, d, ld, st, sz, ex);
    ms_allowin     = 1'b0;
    dcIf.req_ready = 1'b0;
    @(posedge clk); #1;
    es_valid = 1'b0;
    if (issue) begin
      for (int i = 0; i <= rdyDelay; i++) begin
        dcIf.req_ready = (i == rdyDelay);
        dcIf.resp_done = (i == rdyDelay) && respAtAccept;
        @(negedge clk);
        checkOutput("reqValid", dcIf.req_valid, 1);
        checkOutput("issueAllowin", m1_allowin, 0);
        checkOutput("reqOp", dcIf.req_op, st);
        checkOutput("reqTag", dcIf.req_tag, pa >> 12);
        checkOutput("reqIndex", dcIf.req_index, (pa >> 4) % 256);
        checkOutput("reqOffset", dcIf.req_offset, pa % 16);
        checkOutput("reqUncached", dcIf.req_uncached, modelUncached(va));
        checkOutput("reqWstrb", dcIf.req_wstrb, modelStrobe(st, sz, va % 4));
        if (st) checkOutput("reqWdata", dcIf.req_wdata, modelWdata(sz, d));
        checkOutput("issueOutst", outst_cnt, expCnt);
        @(posedge clk); #1;
      end
      dcIf.req_ready = 1'b0;
      dcIf.resp_done = 1'b0;
      if (!respAtAccept) expCnt++;
    end
    for (int i = 0; i <= msDelay; i++) begin
      ms_allowin = (i == msDelay);
      @(negedge clk);
      checkOutput("toMsValid", m1_to_ms_valid, 1);
      checkOutput("doneReqValid", dcIf.req_valid, 0);
      checkOutput("doneAllowin", m1_allowin, ms_allowin);
      checkOutput("m1Ex", m1_ex, ex || mis);
      checkOutput("m1Excode", m1_excode, expCode);
      checkOutput("m1Pc", m1_pc, pc);
      checkOutput("m1Addr", m1_addr, va);
      checkOutput("m1LoadOp", m1_load_op, ld);
      checkOutput("doneOutst", outst_cnt, expCnt);
      @(posedge clk); #1;
    end
    ms_allowin = 1'b0;
    @(negedge clk);
    checkOutput("drainedToMs", m1_to_ms_valid, 0);
    checkOutput("drainedAllowin", m1_allowin, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit          ld;
    bit          st;
    int          kind;
    logic [31:0] va;

    resetn         = 1'b0;
    flush          = 1'b0;
    ms_allowin     = 1'b0;
    dcIf.req_ready = 1'b0;
    dcIf.resp_done = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, SIZE_WORD, 1'b0);

    // Reset state
    #12;
    checkOutput("rstAllowin", m1_allowin, 1);
    checkOutput("rstReqValid", dcIf.req_valid, 0);
    checkOutput("rstToMs", m1_to_ms_valid, 0);
    checkOutput("rstOutst", outst_cnt, 0);
    checkOutput("rstEx", m1_ex, 0);
    checkOutput("rstExcode", m1_excode, 0);
    checkOutput("rstWstrb", dcIf.req_wstrb, 0);
    checkOutput("rstTag", dcIf.req_tag, 0);
    checkOutput("rstPc", m1_pc, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] sw kseg0, ready immediately");
    runOp(32'hBFC0_0100, 32'h8000_1234, 32'hDEAD_BEEF, 1'b0, 1'b1, SIZE_WORD, 1'b0, 0, 0, 1'b0);

    $display("[TB] sb kseg0 lane 2, accept with same-cycle completion");
    runOp(32'hBFC0_0104, 32'h8000_0002, 32'h0000_00AB, 1'b0, 1'b1, SIZE_BYTE, 1'b0, 0, 1, 1'b1);

    $display("[TB] lb kseg1, ready held low three cycles");
    runOp(32'hBFC0_0108, 32'hA000_0003, 32'h0, 1'b1, 1'b0, SIZE_BYTE, 1'b0, 3, 0, 1'b0);

    $display("[TB] issue stalls at the outstanding limit");
    applyStimulus(1'b1, 32'hBFC0_010C, 32'h8000_0040, 32'h0, 1'b1, 1'b0, SIZE_WORD, 1'b0);
    dcIf.req_ready = 1'b1;
    @(posedge clk); #1;
    es_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stallReqValid", dcIf.req_valid, 0);
      checkOutput("stallAllowin", m1_allowin, 0);
      checkOutput("stallOutst", outst_cnt, MAX_OUTST);
      @(posedge clk); #1;
    end
    dcIf.resp_done = 1'b1;
    @(negedge clk);
    checkOutput("stallRespCycle", dcIf.req_valid, 0);
    @(posedge clk); #1;
    dcIf.resp_done = 1'b0;
    expCnt--;
    @(negedge clk);
    checkOutput("unstallReqValid", dcIf.req_valid, 1);
    checkOutput("unstallOutst", outst_cnt, expCnt);
    @(posedge clk); #1;
    dcIf.req_ready = 1'b0;
    expCnt++;
    ms_allowin = 1'b1;
    @(negedge clk);
    checkOutput("unstallToMs", m1_to_ms_valid, 1);
    checkOutput("unstallOutstFull", outst_cnt, MAX_OUTST);
    @(posedge clk); #1;
    ms_allowin = 1'b0;
    pulseResp();

    $display("[TB] flush during issue, flush wins over a new op");
    applyStimulus(1'b1, 32'hBFC0_0110, 32'h0000_1100, 32'h0, 1'b1, 1'b0, SIZE_WORD, 1'b0);
    @(posedge clk); #1;
    es_valid = 1'b0;
    @(negedge clk);
    checkOutput("preFlushReqValid", dcIf.req_valid, 1);
    @(posedge clk); #1;
    flush          = 1'b1;
    dcIf.req_ready = 1'b1;
    applyStimulus(1'b1, 32'hBFC0_0114, 32'h8000_0020, 32'h1234_5678, 1'b0, 1'b1, SIZE_WORD, 1'b0);
    @(negedge clk);
    checkOutput("flushForcesReqLow", dcIf.req_valid, 0);
    @(posedge clk); #1;
    flush          = 1'b0;
    es_valid       = 1'b0;
    dcIf.req_ready = 1'b0;
    @(negedge clk);
    checkOutput("postFlushToMs", m1_to_ms_valid, 0);
    checkOutput("postFlushAllowin", m1_allowin, 1);
    checkOutput("postFlushReqValid", dcIf.req_valid, 0);
    checkOutput("postFlushOutst", outst_cnt, expCnt);
    @(posedge clk); #1;

    $display("[TB] asynchronous reset in the middle of an op");
    applyStimulus(1'b1, 32'hBFC0_0118, 32'h8000_0010, 32'hCAFE_F00D, 1'b0, 1'b1, SIZE_WORD, 1'b0);
    @(posedge clk); #1;
    es_valid = 1'b0;
    @(negedge clk);
    checkOutput("preResetReqValid", dcIf.req_valid, 1);
    checkOutput("preResetOutst", outst_cnt, expCnt);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midRstReqValid", dcIf.req_valid, 0);
    checkOutput("midRstAllowin", m1_allowin, 1);
    checkOutput("midRstOutst", outst_cnt, 0);
    checkOutput("midRstWstrb", dcIf.req_wstrb, 0);
    checkOutput("midRstPc", m1_pc, 0);
    checkOutput("midRstReqOp", dcIf.req_op, 0);
    expCnt = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] misaligned word load and half store");
    runOp(32'hBFC0_011C, 32'h8000_0002, 32'h0, 1'b1, 1'b0, SIZE_WORD, 1'b0, 0, 0, 1'b0);
    runOp(32'hBFC0_0120, 32'h8000_0001, 32'h0000_BEEF, 1'b0, 1'b1, SIZE_HALF, 1'b0, 1, 0, 1'b0);
    runOp(32'hBFC0_0124, 32'h0040_0000, 32'h0, 1'b1, 1'b0, SIZE_WORD, 1'b1, 0, 1, 1'b0);

    $display("[TB] randomized ops");
    for (int n = 0; n < 40; n++) begin
      if (expCnt == MAX_OUTST || (expCnt > 0 && $urandom_range(0, 1) == 1)) pulseResp();
      kind = $urandom_range(0, 4);
      ld   = (kind < 2);
      st   = (kind == 2 || kind == 3);
      va   = {3'($urandom_range(0, 7)), 29'($urandom)};
      runOp(32'($urandom), va, 32'($urandom), ld, st, 2'($urandom_range(0, 2)),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 2),
            (expCnt > 0 && $urandom_range(0, 3) == 0));
    end
    while (expCnt > 0) pulseResp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
